// File: rtl/sram_pixel_writer_pkg.sv
// sram_pixel_writer_pkg
//   Types and constants shared by the SRAM pixel writer and the VGA-side
//   buffer select: write FSM state, SRAM control bundle, default frame
//   geometry / buffer bases, and the RGB888 -> RGB565 packing function.
package sram_pixel_writer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } wr_state_t;

    // SRAM control pins, all active-low except dq_oe.
    typedef struct packed {
        logic ce_n;
        logic we_n;
        logic oe_n;
        logic ub_n;
        logic lb_n;
        logic dq_oe;
    } sram_ctl_t;

    localparam sram_ctl_t CTL_IDLE   = '{ce_n: 1'b1, we_n: 1'b1, oe_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1, dq_oe: 1'b0};
    localparam sram_ctl_t CTL_SETUP  = '{ce_n: 1'b0, we_n: 1'b1, oe_n: 1'b1, ub_n: 1'b0, lb_n: 1'b0, dq_oe: 1'b1};
    localparam sram_ctl_t CTL_STROBE = '{ce_n: 1'b0, we_n: 1'b0, oe_n: 1'b1, ub_n: 1'b0, lb_n: 1'b0, dq_oe: 1'b1};

    localparam int          H_RES_DEF    = 320;
    localparam int          V_RES_DEF    = 240;
    localparam logic [19:0] FB_BASE0_DEF = 20'h00000;
    localparam logic [19:0] FB_BASE1_DEF = 20'h12C00;

    function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

endpackage

// File: rtl/sram_pixel_writer_fb_addr_gen.sv
// sram_pixel_writer_fb_addr_gen
//   Frame-buffer address generator. Tracks x/y of the next pixel and the
//   row base (y*H_RES, accumulated, no multiplier).
//   Ports:
//     clk, reset  clock, synchronous active-high reset
//     advance     a pixel is accepted this cycle; step the position
//     sof         accepted pixel starts a frame; position forced to (0,0)
//     buf_sel     write buffer index: 0 -> FB_BASE0, 1 -> FB_BASE1
//     addr        SRAM word address of the pixel being accepted
//     last        the pixel being accepted is the final one of its frame
module sram_pixel_writer_fb_addr_gen
    import sram_pixel_writer_pkg::*;
#(
    parameter int          H_RES    = H_RES_DEF,
    parameter int          V_RES    = V_RES_DEF,
    parameter logic [19:0] FB_BASE0 = FB_BASE0_DEF,
    parameter logic [19:0] FB_BASE1 = FB_BASE1_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        sof,
    input  logic        buf_sel,
    output logic [19:0] addr,
    output logic        last
);
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

    logic [XW-1:0] x, x_eff;
    logic [YW-1:0] y, y_eff;
    logic [19:0]   row_base, row_eff;
    logic          x_end;

    // sof overrides the stored position so the sof pixel lands on the base.
    always_comb begin
        x_eff   = sof ? '0 : x;
        y_eff   = sof ? '0 : y;
        row_eff = sof ? '0 : row_base;
        x_end   = (x_eff == XW'(H_RES - 1));
        last    = x_end && (y_eff == YW'(V_RES - 1));
        addr    = (buf_sel ? FB_BASE1 : FB_BASE0) + row_eff + 20'(x_eff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else if (advance) begin
            if (last) begin
                x        <= '0;
                y        <= '0;
                row_base <= '0;
            end else if (x_end) begin
                x        <= '0;
                y        <= y_eff + 1'b1;
                row_base <= row_eff + 20'(H_RES);
            end else begin
                x        <= x_eff + 1'b1;
                y        <= y_eff;
                row_base <= row_eff;
            end
        end
    end

endmodule

// File: rtl/sram_pixel_writer.sv
// sram_pixel_writer
//   Takes RGB888 pixels, packs them to RGB565 and writes them into a 16-bit
//   async SRAM double-buffered frame buffer (SETUP cycle, then WE strobe).
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     s_valid/s_ready       pixel handshake; s_data = {R,G,B}; s_sof = frame start
//     sram_addr/sram_dq_out registered write address and data
//     sram_dq_oe            parent drives SRAM_DQ when 1
//     sram_*_n              registered active-low SRAM strobes
//     frame_done            one-cycle pulse after the last pixel's strobe
//     disp_buf              buffer the display side should scan out
//     busy                  a write cycle is in progress
module sram_pixel_writer
    import sram_pixel_writer_pkg::*;
#(
    parameter int          H_RES    = H_RES_DEF,
    parameter int          V_RES    = V_RES_DEF,
    parameter logic [19:0] FB_BASE0 = FB_BASE0_DEF,
    parameter logic [19:0] FB_BASE1 = FB_BASE1_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_sof,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    output logic        frame_done,
    output logic        disp_buf,
    output logic        busy
);
    wr_state_t   state, state_next;
    sram_ctl_t   ctl, ctl_next;
    logic        accept;
    logic        last, last_pend;
    logic        wr_buf;
    logic [19:0] pix_addr;

    assign s_ready = ~reset & (state != SETUP);
    assign accept  = s_valid & s_ready;
    assign busy    = (state != IDLE);

    // last_pend marks that the pixel in flight closes the frame. A pixel
    // accepted during that final STROBE already belongs to the next frame,
    // i.e. to the buffer disp_buf is about to stop pointing at.
    assign wr_buf = ~(disp_buf ^ last_pend);

    sram_pixel_writer_fb_addr_gen #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .FB_BASE0(FB_BASE0),
        .FB_BASE1(FB_BASE1)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .advance(accept),
        .sof    (s_sof),
        .buf_sel(wr_buf),
        .addr   (pix_addr),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = accept ? SETUP : IDLE;
            SETUP:   state_next = STROBE;
            STROBE:  state_next = accept ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so every
    // SRAM pin comes straight from a flop.
    always_comb begin
        ctl_next = CTL_IDLE;
        case (state_next)
            SETUP:   ctl_next = CTL_SETUP;
            STROBE:  ctl_next = CTL_STROBE;
            default: ctl_next = CTL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl         <= CTL_IDLE;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            last_pend   <= 1'b0;
            frame_done  <= 1'b0;
            disp_buf    <= 1'b0;
        end else begin
            ctl        <= ctl_next;
            frame_done <= 1'b0;
            if (accept) begin
                sram_addr   <= pix_addr;
                sram_dq_out <= rgb888_to_565(s_data);
            end
            if (state == STROBE) begin
                frame_done <= last_pend;
                if (last_pend) disp_buf <= ~disp_buf;
            end
            if (accept)                last_pend <= last;
            else if (state == STROBE)  last_pend <= 1'b0;
        end
    end

    assign sram_ce_n  = ctl.ce_n;
    assign sram_we_n  = ctl.we_n;
    assign sram_oe_n  = ctl.oe_n;
    assign sram_ub_n  = ctl.ub_n;
    assign sram_lb_n  = ctl.lb_n;
    assign sram_dq_oe = ctl.dq_oe;

endmodule

// File: tb/tb_sram_pixel_writer.sv
// tb_sram_pixel_writer
//   Drives sram_pixel_writer (4x3 frame) with directed and random pixel
//   streams. An SRAM model captures every WE-low cycle; expectations come
//   from a linear-index frame-buffer model (pixel n of frame f lands at
//   base(f) + n).
module tb_sram_pixel_writer;
    localparam int          H  = 4;
    localparam int          V  = 3;
    localparam logic [19:0] B0 = 20'h00000;
    localparam logic [19:0] B1 = 20'h12C00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_sof = 1'b0;
    logic [23:0] s_data = '0;
    logic        s_ready;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
    logic        frame_done, disp_buf, busy;

    sram_pixel_writer #(.H_RES(H), .V_RES(V), .FB_BASE0(B0), .FB_BASE1(B1)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sof(s_sof), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n), .frame_done(frame_done), .disp_buf(disp_buf), .busy(busy)
    );

    always #10 clk = ~clk;

    int vec_cnt = 0;
    int miscmp = 0;

    // ---------------- SRAM / bus monitor ----------------
    int          cyc = 0;
    logic [19:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [15:0] sram_mem[int];
    int          fd_cnt = 0, fd_cyc = 0, fd_long = 0, bad_strobe = 0;
    logic        fd_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!sram_we_n) begin
            wr_addr_q.push_back(sram_addr);
            wr_data_q.push_back(sram_dq_out);
            wr_cyc_q.push_back(cyc);
            sram_mem[int'(sram_addr)] = sram_dq_out;
            if (sram_ce_n || !sram_oe_n || sram_ub_n || sram_lb_n || !sram_dq_oe) bad_strobe++;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
            if (fd_prev) fd_long++;
        end
        fd_prev = frame_done;
    end

    // ---------------- reference model ----------------
    logic [19:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic [15:0] exp_mem[int];
    int          m_pix = 0;
    bit          m_disp = 1'b0;

    function automatic logic [15:0] pack565(input logic [23:0] d);
        return {d[23:19], d[15:10], d[7:3]};
    endfunction

    task automatic model_push(input logic [23:0] d, input bit sof);
        logic [19:0] a;
        if (sof) m_pix = 0;
        a = (m_disp ? B0 : B1) + 20'(m_pix);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(pack565(d));
        exp_mem[int'(a)] = pack565(d);
        m_pix++;
        if (m_pix == H * V) begin
            m_pix  = 0;
            m_disp = ~m_disp;
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        exp_addr_q.delete(); exp_data_q.delete();
        sram_mem.delete(); exp_mem.delete();
        m_pix = 0; m_disp = 1'b0;
        fd_cnt = 0; fd_long = 0; bad_strobe = 0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0; s_sof = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_logs();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one pixel and hold it until it is accepted (bounded wait).
    task automatic push(input logic [23:0] d, input bit sof);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_sof = sof;
        @(negedge clk);
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vec_cnt++; miscmp++;
            $display("FAIL push_timeout: s_ready stayed %b, expected 1 within 20 cycles", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_sof = 1'b0;
        model_push(d, sof);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b1; s_data = 24'h123456;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (s_ready !== 1'b0) begin miscmp++; $display("FAIL rst_ready got %b exp 0", s_ready); end
        vec_cnt++;
        if ({sram_addr, sram_dq_out} !== 36'h0) begin
            miscmp++; $display("FAIL rst_addr_data got %h/%h exp 0/0", sram_addr, sram_dq_out);
        end
        vec_cnt++;
        if ({sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 6'b111110) begin
            miscmp++;
            $display("FAIL rst_strobes got %b exp 111110",
                     {sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n, sram_dq_oe});
        end
        vec_cnt++;
        if ({frame_done, disp_buf, busy} !== 3'b000) begin
            miscmp++; $display("FAIL rst_flags got %b exp 000", {frame_done, disp_buf, busy});
        end
        @(posedge clk);
        #1 reset = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({s_ready, busy, sram_we_n} !== 3'b101) begin
            miscmp++; $display("FAIL post_rst got ready/busy/we_n=%b exp 101", {s_ready, busy, sram_we_n});
        end
        clear_logs();
    endtask

    task automatic test_single();
        do_reset();
        push(24'hFF8040, 1'b1);
        @(negedge clk);
        vec_cnt++;
        if ({sram_addr, sram_dq_out, sram_ce_n, sram_we_n, sram_dq_oe, s_ready} !==
            {20'h12C00, 16'hFC08, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            miscmp++;
            $display("FAIL single_setup got addr=%h dq=%h ce_n=%b we_n=%b oe=%b rdy=%b exp 12c00 fc08 0 1 1 0",
                     sram_addr, sram_dq_out, sram_ce_n, sram_we_n, sram_dq_oe, s_ready);
        end
        @(negedge clk);
        vec_cnt++;
        if ({sram_we_n, sram_ce_n, sram_dq_oe} !== 3'b001) begin
            miscmp++; $display("FAIL single_strobe got we_n/ce_n/oe=%b exp 001", {sram_we_n, sram_ce_n, sram_dq_oe});
        end
        @(negedge clk);
        vec_cnt++;
        if ({sram_dq_oe, sram_we_n, sram_ce_n, busy, sram_addr, sram_dq_out} !==
            {1'b0, 1'b1, 1'b1, 1'b0, 20'h12C00, 16'hFC08}) begin
            miscmp++;
            $display("FAIL single_idle got oe=%b we_n=%b ce_n=%b busy=%b addr=%h dq=%h exp 0 1 1 0 12c00 fc08",
                     sram_dq_oe, sram_we_n, sram_ce_n, busy, sram_addr, sram_dq_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push(24'($urandom), i == 0);
            vec_cnt++;
            if (s_ready !== 1'b0) begin miscmp++; $display("FAIL b2b_ready_setup px%0d got %b exp 0", i, s_ready); end
        end
        idle(3);
        vec_cnt++;
        if (wr_addr_q.size() !== 10) begin
            miscmp++; $display("FAIL b2b_count got %0d exp 10", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                vec_cnt++;
                if ({wr_addr_q[i], wr_data_q[i]} !== {B1 + 20'(i), exp_data_q[i]}) begin
                    miscmp++;
                    $display("FAIL b2b_write px%0d got %h/%h exp %h/%h", i, wr_addr_q[i], wr_data_q[i],
                             B1 + 20'(i), exp_data_q[i]);
                end
                if (i > 0) begin
                    vec_cnt++;
                    if (wr_cyc_q[i] - wr_cyc_q[i-1] !== 2) begin
                        miscmp++; $display("FAIL b2b_spacing px%0d got %0d exp 2", i, wr_cyc_q[i] - wr_cyc_q[i-1]);
                    end
                end
            end
        end
        vec_cnt++;
        if (bad_strobe !== 0) begin miscmp++; $display("FAIL b2b_strobes got %0d bad exp 0", bad_strobe); end
    endtask

    task automatic test_line_wrap();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            if (i == 11) begin
                vec_cnt++;
                if (disp_buf !== 1'b0) begin miscmp++; $display("FAIL wrap_disp_before got %b exp 0", disp_buf); end
            end
            push(24'($urandom), i == 0);
        end
        idle(3);
        vec_cnt++;
        if (wr_addr_q.size() !== 13) begin
            miscmp++; $display("FAIL wrap_count got %0d exp 13", wr_addr_q.size());
        end else begin
            vec_cnt++;
            if (wr_addr_q[4] !== B1 + 20'd4) begin miscmp++; $display("FAIL wrap_px5 got %h exp %h", wr_addr_q[4], B1 + 20'd4); end
            vec_cnt++;
            if (wr_addr_q[12] !== B0) begin miscmp++; $display("FAIL wrap_px13 got %h exp %h", wr_addr_q[12], B0); end
            vec_cnt++;
            if (fd_cyc !== wr_cyc_q[11] + 1) begin
                miscmp++; $display("FAIL wrap_fd_timing got cyc %0d exp %0d", fd_cyc, wr_cyc_q[11] + 1);
            end
            for (int i = 0; i < 13; i++) begin
                vec_cnt++;
                if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr_q[i], exp_data_q[i]}) begin
                    miscmp++;
                    $display("FAIL wrap_write px%0d got %h/%h exp %h/%h", i, wr_addr_q[i], wr_data_q[i],
                             exp_addr_q[i], exp_data_q[i]);
                end
            end
        end
        vec_cnt++;
        if ({fd_cnt, fd_long} !== {32'd1, 32'd0}) begin
            miscmp++; $display("FAIL wrap_fd got pulses=%0d long=%0d exp 1/0", fd_cnt, fd_long);
        end
        vec_cnt++;
        if (disp_buf !== 1'b1) begin miscmp++; $display("FAIL wrap_disp_after got %b exp 1", disp_buf); end
    endtask

    task automatic test_sof_mid();
        do_reset();
        for (int i = 0; i < 10; i++) push(24'($urandom), (i == 0) || (i == 6));
        idle(3);
        vec_cnt++;
        if (wr_addr_q.size() !== 10) begin
            miscmp++; $display("FAIL sof_count got %0d exp 10", wr_addr_q.size());
        end else begin
            vec_cnt++;
            if (wr_addr_q[6] !== B1) begin miscmp++; $display("FAIL sof_px7 got %h exp %h", wr_addr_q[6], B1); end
            for (int i = 0; i < 10; i++) begin
                vec_cnt++;
                if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr_q[i], exp_data_q[i]}) begin
                    miscmp++;
                    $display("FAIL sof_write px%0d got %h/%h exp %h/%h", i, wr_addr_q[i], wr_data_q[i],
                             exp_addr_q[i], exp_data_q[i]);
                end
            end
        end
        vec_cnt++;
        if ({fd_cnt, disp_buf} !== {32'd0, 1'b0}) begin
            miscmp++; $display("FAIL sof_no_swap got pulses=%0d disp=%b exp 0/0", fd_cnt, disp_buf);
        end
        // 4 pixels of the restarted frame written; 8 more complete it.
        for (int i = 0; i < 8; i++) push(24'($urandom), 1'b0);
        idle(3);
        vec_cnt++;
        if ({fd_cnt, disp_buf} !== {32'd1, 1'b1}) begin
            miscmp++; $display("FAIL sof_restart_frame got pulses=%0d disp=%b exp 1/1", fd_cnt, disp_buf);
        end
    endtask

    task automatic test_reset_strobe();
        logic [23:0] d;
        do_reset();
        for (int i = 0; i < 14; i++) push(24'($urandom), i == 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({sram_we_n, disp_buf} !== 2'b01) begin
            miscmp++; $display("FAIL rs_in_strobe got we_n/disp=%b exp 01", {sram_we_n, disp_buf});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({busy, sram_we_n, sram_ce_n, sram_dq_oe, disp_buf} !== 5'b01100) begin
            miscmp++;
            $display("FAIL rs_after got busy/we_n/ce_n/oe/disp=%b exp 01100",
                     {busy, sram_we_n, sram_ce_n, sram_dq_oe, disp_buf});
        end
        idle(2);
        vec_cnt++;
        if (fd_cnt !== 1) begin miscmp++; $display("FAIL rs_fd got %0d pulses exp 1", fd_cnt); end
        clear_logs();
        d = 24'($urandom);
        push(d, 1'b0);
        idle(3);
        vec_cnt++;
        if (wr_addr_q.size() !== 1) begin
            miscmp++; $display("FAIL rs_next_count got %0d exp 1", wr_addr_q.size());
        end else begin
            vec_cnt++;
            if ({wr_addr_q[0], wr_data_q[0]} !== {B1, pack565(d)}) begin
                miscmp++; $display("FAIL rs_next_write got %h/%h exp %h/%h", wr_addr_q[0], wr_data_q[0], B1, pack565(d));
            end
        end
    endtask

    task automatic test_random();
        int n_bad = 0;
        do_reset();
        for (int i = 0; i < 2 * H * V; i++) begin
            idle($urandom_range(0, 3));
            push(24'($urandom), i == 0);
        end
        idle(4);
        foreach (exp_mem[k]) begin
            if (!sram_mem.exists(k) || sram_mem[k] !== exp_mem[k]) n_bad++;
        end
        vec_cnt++;
        if (n_bad !== 0) begin miscmp++; $display("FAIL rand_mem got %0d bad words exp 0", n_bad); end
        vec_cnt++;
        if (wr_addr_q.size() !== 2 * H * V) begin
            miscmp++; $display("FAIL rand_count got %0d exp %0d", wr_addr_q.size(), 2 * H * V);
        end
        vec_cnt++;
        if ({fd_cnt, fd_long, bad_strobe} !== {32'd2, 32'd0, 32'd0}) begin
            miscmp++; $display("FAIL rand_fd got pulses=%0d long=%0d badstrobe=%0d exp 2/0/0", fd_cnt, fd_long, bad_strobe);
        end
        vec_cnt++;
        if (disp_buf !== 1'b0) begin miscmp++; $display("FAIL rand_disp got %b exp 0", disp_buf); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_line_wrap();
        test_sof_mid();
        test_reset_strobe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
